// File: rtl/sha_block_loader.sv
// sha_block_loader: front end of the pipelined SHA core. Collects sixteen 32-bit
// message words into the schedule window, pairs them with the midstate sampled
// alongside word 0, and presents {state, W} to round stage 0 over valid/ready.
// midstate_i/state_o pack a..h with a in bits [255:224] and h in bits [31:0].
// Optional build macro: SHA_LOADER_BYTESWAP_EN byte-reverses each accepted word
// before storage (little-endian hosts). Without it words are stored as received.

module sha_block_loader #(
  parameter int BLOCK_WORDS = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [255:0]           midstate_i,
  input  logic [31:0]            word_i,
  input  logic                   word_valid_i,
  output logic                   word_ready_o,
  input  logic                   abort_i,
  output logic [255:0]           state_o,
  output logic [15:0][31:0]      W_o,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic [COUNT_WIDTH-1:0] block_count_o
);

  localparam int IDX_W = 4;

  // The round pipeline is built around a 16-word window; any other size is a build error.
  if (BLOCK_WORDS != 16) begin : g_bad_block_words
    $error("sha_block_loader: BLOCK_WORDS must be 16");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   word_ready_q, word_ready_d;
  logic                   block_valid_q, block_valid_d;
  logic [15:0][31:0]      w_q, w_d;
  logic [255:0]           hash_q, hash_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            word_in;
  logic                   accept;

`ifdef SHA_LOADER_BYTESWAP_EN
  // Little-endian host: reverse byte order so the window holds SHA-native words.
  assign word_in = {word_i[7:0], word_i[15:8], word_i[23:16], word_i[31:24]};
`else
  // Big-endian host: words already in SHA-native order.
  assign word_in = word_i;
`endif

  // Only a registered ready may qualify a beat, so acceptance never depends on this cycle's logic.
  assign accept = word_valid_i && word_ready_q;

  // Next-state and datapath update for the FILL/HOLD loop.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves it unassigned, which would infer a latch.
    state_d       = state_q;
    idx_d         = idx_q;
    word_ready_d  = word_ready_q;
    block_valid_d = block_valid_q;
    w_d           = w_q;
    hash_d        = hash_q;
    count_d       = count_q;

    unique case (state_q)
      FILL: begin
        word_ready_d = 1'b1;
        if (abort_i) begin
          // Partial block and any coinciding word are discarded.
          idx_d = '0;
        end else if (accept) begin
          w_d[idx_q] = word_in;
          if (idx_q == '0) begin
            hash_d = midstate_i;
          end
          if (idx_q == IDX_W'(BLOCK_WORDS - 1)) begin
            idx_d         = '0;
            state_d       = HOLD;
            word_ready_d  = 1'b0;
            block_valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        // Handshake outranks abort: a block the pipeline took is counted.
        if (block_ready_i) begin
          block_valid_d = 1'b0;
          count_d       = count_q + COUNT_WIDTH'(1);
          state_d       = FILL;
          word_ready_d  = 1'b1;
        end else if (abort_i) begin
          block_valid_d = 1'b0;
          state_d       = FILL;
          word_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State register; reset returns every output to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the window is reset too (not left as uninitialised storage) because
    // W_o has a defined reset value of zero at the port.
    if (!rst_n) begin
      state_q       <= FILL;
      idx_q         <= '0;
      word_ready_q  <= 1'b0;
      block_valid_q <= 1'b0;
      w_q           <= '0;
      hash_q        <= '0;
      count_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q       <= state_d;
      idx_q         <= idx_d;
      word_ready_q  <= word_ready_d;
      block_valid_q <= block_valid_d;
      w_q           <= w_d;
      hash_q        <= hash_d;
      count_q       <= count_d;
    end
  end

  assign word_ready_o  = word_ready_q;
  assign block_valid_o = block_valid_q;
  assign W_o           = w_q;
  assign state_o       = hash_q;
  assign block_count_o = count_q;

endmodule

// File: tb/tb_sha_block_loader.sv
// Directed bench for sha_block_loader: each complete block's expected {state, W}
// is pushed to a scoreboard queue when driven and popped when block_valid_o rises.

module tb_sha_block_loader;

  localparam int CW = 32;

  logic              clk;
  logic              rst_n;
  logic [255:0]      midstate_i;
  logic [31:0]       word_i;
  logic              word_valid_i;
  logic              word_ready_o;
  logic              abort_i;
  logic [255:0]      state_o;
  logic [15:0][31:0] W_o;
  logic              block_valid_o;
  logic              block_ready_i;
  logic [CW-1:0]     block_count_o;

  sha_block_loader #(.BLOCK_WORDS(16), .COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .midstate_i    (midstate_i),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .abort_i       (abort_i),
    .state_o       (state_o),
    .W_o           (W_o),
    .block_valid_o (block_valid_o),
    .block_ready_i (block_ready_i),
    .block_count_o (block_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [255:0]      st;
    logic [15:0][31:0] w;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   exp_count = 0;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef SHA_LOADER_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until it is accepted (bounded).
  task automatic send_word(input logic [31:0] w);
    bit done;
    done = 1'b0;
    word_i = w;
    word_valid_i = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      done = word_ready_o;
      tick();
    end
    word_valid_i = 1'b0;
    if (!done) check("word_accept_timeout", done, 1'b1);
  endtask

  // Drive a full block; midstate_i is corrupted after word 0 so only the word-0 sample is valid.
  task automatic send_block(input logic [255:0] mid, input logic [15:0][31:0] words,
                            input bit gap, input string tag);
    exp_t e;
    e.st = mid;
    for (int i = 0; i < 16; i++) e.w[i] = stored(words[i]);
    sb_q.push_back(e);
    midstate_i = mid;
    for (int i = 0; i < 16; i++) begin
      send_word(words[i]);
      if (i == 0) midstate_i = ~mid;
      if (i == 14) check({tag, "_not_valid_early"}, block_valid_o, 1'b0);
      if (gap && i < 15) tick();
    end
  endtask

  // Wait (bounded) for block_valid_o, then compare against the scoreboard head.
  task automatic wait_block(input string tag);
    exp_t e;
    for (int n = 0; n < 40 && !block_valid_o; n++) tick();
    check({tag, "_valid"}, block_valid_o, 1'b1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_state"}, state_o, e.st);
      check({tag, "_W"}, W_o, e.w);
    end
  endtask

  task automatic expect_taken(input string tag);
    tick();
    check({tag, "_valid_drop"}, block_valid_o, 1'b0);
    check({tag, "_count"}, block_count_o, CW'(exp_count));
    check({tag, "_ready_back"}, word_ready_o, 1'b1);
  endtask

  logic [15:0][31:0] abc, seq, blk;
  logic [255:0]      mid2;
  logic [15:0][31:0] hold_w;

  initial begin
    abc = '0;
    abc[0] = 32'h61626380;
    abc[15] = 32'h00000018;
    for (int i = 0; i < 16; i++) seq[i] = 32'(i);
    mid2 = {8{32'h0badf00d}} ^ IV;

    rst_n = 1'b0;
    midstate_i = '0;
    word_i = '0;
    word_valid_i = 1'b0;
    abort_i = 1'b0;
    block_ready_i = 1'b0;

    // Reset values
    #12;
    check("rst_word_ready", word_ready_o, 1'b0);
    check("rst_block_valid", block_valid_o, 1'b0);
    check("rst_W", W_o, '0);
    check("rst_state", state_o, '0);
    check("rst_count", block_count_o, '0);
    rst_n = 1'b1;
    tick();
    check("rel_word_ready", word_ready_o, 1'b1);

    // 1: "abc" block, pipeline always ready; valid must appear right after the 16th word
    block_ready_i = 1'b1;
    send_block(IV, abc, 1'b0, "t1");
    check("t1_latency", block_valid_o, 1'b1);
    wait_block("t1");
    check("t1_W0", W_o[0], stored(32'h61626380));
    check("t1_W15", W_o[15], stored(32'h00000018));
    check("t1_a", state_o[255:224], 32'h6a09e667);
    check("t1_h", state_o[31:0], 32'h5be0cd19);
    check("t1_ready_in_hold", word_ready_o, 1'b0);
    exp_count++;
    expect_taken("t1");

    // 2: backpressure for 10 cycles; a word offered in HOLD must not be taken
    block_ready_i = 1'b0;
    blk = abc;
    blk[3] = 32'h12345678;
    send_block(mid2, blk, 1'b0, "t2");
    wait_block("t2");
    hold_w = W_o;
    word_i = 32'hffffffff;
    word_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t2_hold_valid", block_valid_o, 1'b1);
      check("t2_hold_ready", word_ready_o, 1'b0);
      check("t2_hold_W", W_o, hold_w);
      check("t2_hold_state", state_o, mid2);
      check("t2_hold_count", block_count_o, CW'(exp_count));
    end
    word_valid_i = 1'b0;
    block_ready_i = 1'b1;
    exp_count++;
    expect_taken("t2");

    // 3: gappy stream reproduces test 1
    send_block(IV, abc, 1'b1, "t3");
    wait_block("t3");
    exp_count++;
    expect_taken("t3");

    // 4: abort after 7 words (coinciding word dropped), then 0x00..0x0F
    midstate_i = IV;
    for (int i = 0; i < 7; i++) send_word(32'hcafe0000 | 32'(i));
    word_i = 32'hdeadbeef;
    word_valid_i = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    word_valid_i = 1'b0;
    send_block(mid2, seq, 1'b0, "t4");
    wait_block("t4");
    exp_count++;
    expect_taken("t4");

    // 5a: abort in HOLD without ready -> dropped, not counted
    block_ready_i = 1'b0;
    send_block(IV, seq, 1'b0, "t5a");
    wait_block("t5a");
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5a_valid_drop", block_valid_o, 1'b0);
    check("t5a_count", block_count_o, CW'(exp_count));
    check("t5a_ready_back", word_ready_o, 1'b1);

    // 5b: abort together with ready -> handshake wins, counted
    send_block(mid2, abc, 1'b0, "t5b");
    wait_block("t5b");
    abort_i = 1'b1;
    block_ready_i = 1'b1;
    exp_count++;
    expect_taken("t5b");
    abort_i = 1'b0;
    block_ready_i = 1'b0;

    // 6: reset after 9 words wipes progress and outputs asynchronously
    midstate_i = mid2;
    for (int i = 0; i < 9; i++) send_word(32'h55550000 | 32'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ready", word_ready_o, 1'b0);
    check("t6_rst_count", block_count_o, '0);
    check("t6_rst_W", W_o, '0);
    check("t6_rst_state", state_o, '0);
    exp_count = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_rel_ready", word_ready_o, 1'b1);
    blk = seq;
    blk[0] = 32'h80636261;
    send_block(IV, blk, 1'b0, "t6");
    wait_block("t6");
`ifdef SHA_LOADER_BYTESWAP_EN
    check("t6_swap_W0", W_o[0], 32'h61626380);
`else
    check("t6_raw_W0", W_o[0], 32'h80636261);
`endif
    // Reset while a block is held drops block_valid_o without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", block_valid_o, 1'b0);
    check("t6_rst_ready2", word_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_rel_ready2", word_ready_o, 1'b1);
    check("t6_rel_count", block_count_o, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
